// File: rtl/mux_bus_arbiter.sv
// Round-robin owner of the 4:1 8-bit data mux select: one-hot grant to sources a..d,
// with an optional hold limit that forces a one-cycle gap when a rival is waiting.
//
//   state | meaning
//   IDLE  | no owner; any request is arbitrated at the next edge
//   GRANT | one owner drives the mux; release, hold-limit or stay evaluated each edge
//   GAP   | single dead cycle after a hold-limit preemption (expire pulses here)
module mux_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       bus_valid,
  output logic       expire
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic [1:0]       last;
  logic [1:0]       last_nxt;
  logic [1:0]       select_nxt;
  logic [3:0]       gnt_nxt;
  logic             expire_nxt;
  logic [1:0]       winner;
  logic             owner_req;
  logic             rivals;
  logic             hold_hit;

  // Search order from the last owner l: l+1, l+2, l+3, then l itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    winner    = rr_pick(req, last);
    owner_req = req[select];
    rivals    = |(req & ~gnt);
    hold_hit  = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    last_nxt   = last;
    select_nxt = select;
    gnt_nxt    = gnt;
    expire_nxt = 1'b0;

    case (state)
      IDLE, GAP: begin
        if (req != 4'b0000) begin
          state_nxt  = GRANT;
          gnt_nxt    = 4'b0001 << winner;
          select_nxt = winner;
          last_nxt   = winner;
          hold_nxt   = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Owner released: hand over directly when someone else is waiting.
          if (rivals) begin
            gnt_nxt    = 4'b0001 << winner;
            select_nxt = winner;
            last_nxt   = winner;
            hold_nxt   = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else if (hold_hit && rivals) begin
          state_nxt  = GAP;
          gnt_nxt    = 4'b0000;
          expire_nxt = 1'b1;
        end else if (hold_cnt < HOLD_LIM) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last      <= 2'd3;
      select    <= 2'd0;
      gnt       <= 4'b0000;
      bus_valid <= 1'b0;
      expire    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      last      <= last_nxt;
      select    <= select_nxt;
      gnt       <= gnt_nxt;
      bus_valid <= |gnt_nxt;
      expire    <= expire_nxt;
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: a hold-limited instance and an unlimited instance share
// clock and reset; expected grant sequences are queued and popped as outputs appear.
module tb_mux_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_u;
  logic [3:0] gnt;
  logic [3:0] gnt_u;
  logic [1:0] select;
  logic [1:0] select_u;
  logic       bus_valid;
  logic       bus_valid_u;
  logic       expire;
  logic       expire_u;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] exp_q[$];
  logic       exp_x[$];

  always #5 clk = ~clk;

  mux_bus_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .select   (select),
    .bus_valid(bus_valid),
    .expire   (expire)
  );

  mux_bus_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut_u (
    .clk      (clk),
    .rst      (rst),
    .req      (req_u),
    .gnt      (gnt_u),
    .select   (select_u),
    .bus_valid(bus_valid_u),
    .expire   (expire_u)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    req_u = 4'b1111;
    step();
    step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (select !== 2'd0) $display("FAIL reset_select: got %0d want 0", select); else n_pass++;
    n_total++; if (bus_valid !== 1'b0) $display("FAIL reset_bus_valid: got %b want 0", bus_valid); else n_pass++;
    n_total++; if (expire !== 1'b0) $display("FAIL reset_expire: got %b want 0", expire); else n_pass++;
    rst   = 1'b0;
    req   = 4'b0000;
    req_u = 4'b0000;
    step();
  endtask

  task automatic test_single();
    req = 4'b0100;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    n_total++; if (select !== 2'd2) $display("FAIL single_select: got %0d want 2", select); else n_pass++;
    n_total++; if (bus_valid !== 1'b1) $display("FAIL single_bus_valid: got %b want 1", bus_valid); else n_pass++;
    req = 4'b0000;
    step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL release_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (bus_valid !== 1'b0) $display("FAIL release_bus_valid: got %b want 0", bus_valid); else n_pass++;
    n_total++; if (select !== 2'd2) $display("FAIL release_select_hold: got %0d want 2", select); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [3:0] prev;
    logic [3:0] e_gnt;
    int         held[4];
    int         gaps;
    bit         started;
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    prev    = 4'b0000;
    gaps    = 0;
    started = 1'b0;
    held    = '{default: 0};
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      step();
      if (gnt != prev && gnt != 4'b0000) begin
        e_gnt   = exp_q.pop_front();
        started = 1'b1;
        n_total++; if (gnt !== e_gnt) $display("FAIL fair_order: got %b want %b", gnt, e_gnt); else n_pass++;
      end else if (started && gnt == 4'b0000) begin
        gaps++;
      end
      prev = gnt;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          held[i]++;
          if (held[i] == 2) req[i] = 1'b0;
        end
      end
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL fair_timeout: %0d grants outstanding want 0", exp_q.size()); else n_pass++;
    n_total++; if (gaps != 0) $display("FAIL fair_no_gap: got %0d idle cycles want 0", gaps); else n_pass++;
    exp_q.delete();
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] e_gnt;
    logic       e_x;
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(4'b0001);
      exp_x.push_back(1'b0);
    end
    exp_q.push_back(4'b0000);
    exp_x.push_back(1'b1);
    exp_q.push_back(4'b0010);
    exp_x.push_back(1'b0);
    for (int c = 1; c <= 10; c++) begin
      step();
      e_gnt = exp_q.pop_front();
      e_x   = exp_x.pop_front();
      n_total++; if (gnt !== e_gnt) $display("FAIL timeout_gnt cycle %0d: got %b want %b", c, gnt, e_gnt); else n_pass++;
      n_total++; if (expire !== e_x) $display("FAIL timeout_expire cycle %0d: got %b want %b", c, expire, e_x); else n_pass++;
      if (c == 3) req[1] = 1'b1;
    end
    n_total++; if (select !== 2'd1) $display("FAIL timeout_select: got %0d want 1", select); else n_pass++;
    n_total++; if (bus_valid !== 1'b1) $display("FAIL timeout_bus_valid: got %b want 1", bus_valid); else n_pass++;
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_unlimited();
    int bad_g;
    int bad_x;
    rst   = 1'b1;
    req_u = 4'b0000;
    step();
    rst   = 1'b0;
    req_u = 4'b0011;
    bad_g = 0;
    bad_x = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (gnt_u !== 4'b0001) bad_g++;
      if (expire_u !== 1'b0) bad_x++;
    end
    n_total++; if (bad_g != 0) $display("FAIL unlimited_gnt: got %0d cycles not 0001 want 0", bad_g); else n_pass++;
    n_total++; if (bad_x != 0) $display("FAIL unlimited_expire: got %0d expire cycles want 0", bad_x); else n_pass++;
    req_u = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0100;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL mid_pre_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    req = 4'b1100;
    rst = 1'b1;
    step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (select !== 2'd0) $display("FAIL mid_rst_select: got %0d want 0", select); else n_pass++;
    n_total++; if (bus_valid !== 1'b0) $display("FAIL mid_rst_bus_valid: got %b want 0", bus_valid); else n_pass++;
    n_total++; if (expire !== 1'b0) $display("FAIL mid_rst_expire: got %b want 0", expire); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL mid_regrant_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    n_total++; if (select !== 2'd2) $display("FAIL mid_regrant_select: got %0d want 2", select); else n_pass++;
    req = 4'b0000;
    step();
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    req_u = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_unlimited();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
    $fatal(1);
  end

endmodule
